uart_tx_scheduler: RTL and testbench

Shares one uart_transmitter between NUM_SOURCES byte-stream requesters. Packets are arbitrated round-robin and each grant is held until the packet ends. The block can prefix each packet with a source-ID header byte. It paces bytes off the transmitter's enable/ready handshake, and enforces a per-packet length limit and a mid-packet stall timeout. It sits between the analyser's capture/report sources and the host UART.

---
 rtl/uart_tx_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one uart_transmitter between NUM_SOURCES byte-stream requesters.
// Whole packets are arbitrated round-robin, and a grant is held until the
// packet ends. Each packet can optionally be prefixed with a source-ID header
// byte. Bytes are paced from the transmitter's enable/ready handshake. After
// every issued byte the block waits for ready to drop, and then for it to
// return, before it issues again.
//
// A grant is force-released after MAX_PACKET_BYTES data bytes that have no
// src_last (truncation). A grant is revoked when the granted source holds
// src_valid low mid-packet for STALL_TIMEOUT_CLKS clocks (abort).
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   src_valid      per-source byte valid
//   src_data       per-source byte, source i at [8i+7:8i]
//   src_last       per-source last-byte-of-packet marker
//   src_ready      one-cycle accept pulse per byte (granted source only)
//   tx_enable      to uart_transmitter.enable
//   tx_data        to uart_transmitter.data
//   tx_ready       from uart_transmitter.ready
//   grant_valid    a source currently holds the transmitter
//   grant_id       granted source index
//   pkt_truncated  one-cycle pulse: grant released at the length limit
//   pkt_aborted    one-cycle pulse: grant revoked by stall timeout
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int         NUM_SOURCES        = 4,
    parameter bit         ADD_HEADER         = 1'b1,
    parameter logic [7:0] HEADER_BASE        = 8'hA0,
    parameter int         MAX_PACKET_BYTES   = 64,
    parameter int         STALL_TIMEOUT_CLKS = 1000,
    localparam int        ID_W               = $clog2(NUM_SOURCES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SOURCES-1:0]   src_valid,
    input  logic [8*NUM_SOURCES-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]   src_last,
    output logic [NUM_SOURCES-1:0]   src_ready,
    output logic                     tx_enable,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic                     pkt_truncated,
    output logic                     pkt_aborted
);

    localparam int STALL_W = $clog2(STALL_TIMEOUT_CLKS + 1);

    localparam logic [7:0]         LAST_BYTE_IDX = 8'(MAX_PACKET_BYTES - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT   = STALL_W'(STALL_TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HEADER    = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RELEASE   = 3'd5
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [7:0]          byte_cnt_r;
    logic [STALL_W-1:0]  stall_cnt_r;
    logic                end_flag_r;
    logic                trunc_flag_r;

    logic                sel_valid_s;
    logic                sel_last_s;
    logic [7:0]          sel_data_s;
    logic [7:0]          hdr_byte_s;
    logic                issue_hdr_s;
    logic                issue_send_s;
    logic                arb_found_s;
    logic [ID_W-1:0]     arb_id_s;
    logic [ID_W-1:0]     cand_s;

    // Mux the granted source's request onto a single set of signals.
    always_comb begin
        sel_valid_s = src_valid[grant_id];
        sel_last_s  = src_last[grant_id];
        sel_data_s  = src_data[{grant_id, 3'b000} +: 8];
        hdr_byte_s  = HEADER_BASE + 8'(grant_id);
    end

    // Issue conditions. These are combinational so that a byte goes out in the same cycle ready is seen.
    always_comb begin
        issue_hdr_s  = (state_r == ST_HEADER) && tx_ready;
        issue_send_s = (state_r == ST_SEND) && tx_ready && sel_valid_s;
    end

    // Drive the transmitter and the per-source accept pulse from the issue conditions.
    always_comb begin
        tx_enable = issue_hdr_s || issue_send_s;
        if (issue_hdr_s) begin
            tx_data = hdr_byte_s;
        end else if (issue_send_s) begin
            tx_data = sel_data_s;
        end else begin
            tx_data = 8'h00;
        end
        for (int i = 0; i < NUM_SOURCES; i++) begin
            src_ready[i] = issue_send_s && (grant_id == ID_W'(i));
        end
    end

    // Round-robin search that starts one past the last granted source and wraps.
    always_comb begin
        arb_found_s = 1'b0;
        arb_id_s    = {ID_W{1'b0}};
        cand_s      = {ID_W{1'b0}};
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % NUM_SOURCES);
            if (!arb_found_s && src_valid[cand_s]) begin
                arb_found_s = 1'b1;
                arb_id_s    = cand_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Packet scheduling FSM, with registered grant and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= ID_W'(NUM_SOURCES - 1);
            byte_cnt_r    <= 8'd0;
            stall_cnt_r   <= {STALL_W{1'b0}};
            end_flag_r    <= 1'b0;
            trunc_flag_r  <= 1'b0;
            grant_valid   <= 1'b0;
            grant_id      <= {ID_W{1'b0}};
            pkt_truncated <= 1'b0;
            pkt_aborted   <= 1'b0;
        end else begin
            pkt_truncated <= 1'b0;
            pkt_aborted   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_found_s) begin
                        grant_id     <= arb_id_s;
                        grant_valid  <= 1'b1;
                        byte_cnt_r   <= 8'd0;
                        stall_cnt_r  <= {STALL_W{1'b0}};
                        end_flag_r   <= 1'b0;
                        trunc_flag_r <= 1'b0;
                        state_r      <= ADD_HEADER ? ST_HEADER : ST_SEND;
                    end
                end

                ST_HEADER: begin
                    // No stall counting here: the header does not depend on the source.
                    if (issue_hdr_s) begin
                        end_flag_r <= 1'b0;
                        state_r    <= ST_WAIT_BUSY;
                    end
                end

                ST_SEND: begin
                    if (issue_send_s) begin
                        byte_cnt_r  <= byte_cnt_r + 8'd1;
                        stall_cnt_r <= {STALL_W{1'b0}};
                        if (sel_last_s) begin
                            end_flag_r   <= 1'b1;
                            trunc_flag_r <= 1'b0;
                        end else if (byte_cnt_r == LAST_BYTE_IDX) begin
                            // The length limit is reached with no src_last, so the
                            // rest of this source's bytes must re-arbitrate.
                            end_flag_r   <= 1'b1;
                            trunc_flag_r <= 1'b1;
                        end else begin
                            end_flag_r   <= 1'b0;
                        end
                        state_r <= ST_WAIT_BUSY;
                    end else if (!sel_valid_s) begin
                        if (stall_cnt_r == STALL_LIMIT) begin
                            pkt_aborted <= 1'b1;
                            state_r     <= ST_RELEASE;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
                        end
                    end
                end

                ST_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (tx_ready) begin
                        state_r <= end_flag_r ? ST_RELEASE : ST_SEND;
                    end
                end

                ST_RELEASE: begin
                    rr_ptr_r      <= grant_id;
                    grant_valid   <= 1'b0;
                    pkt_truncated <= trunc_flag_r;
                    trunc_flag_r  <= 1'b0;
                    end_flag_r    <= 1'b0;
                    state_r       <= ST_IDLE;
                end

                default: begin
                    grant_valid <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_scheduler. The parameters are 4 sources, a header base
// of A0, a 4-byte packet limit and a 10-clock stall timeout.
//
// The bench contains the following models:
//   - Source models: a byte FIFO per source. Valid is high while the FIFO
//     holds a byte, and the head byte is popped on src_ready.
//   - Transmitter model: ready is held low for BUSY clocks after each accepted
//     enable.
//   - Scoreboard: the expected transmit bytes, in arbitration order, are
//     queued when the stimulus is loaded. A monitor records every issued byte
//     together with a pacing-legality flag.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NS   = 4;
    localparam int BUSY = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NS-1:0]   src_valid;
    logic [8*NS-1:0] src_data;
    logic [NS-1:0]   src_last;
    logic [NS-1:0]   src_ready;
    logic            tx_enable;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b1;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            pkt_truncated;
    logic            pkt_aborted;

    uart_tx_scheduler #(
        .NUM_SOURCES       (NS),
        .ADD_HEADER        (1'b1),
        .HEADER_BASE       (8'hA0),
        .MAX_PACKET_BYTES  (4),
        .STALL_TIMEOUT_CLKS(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .tx_enable    (tx_enable),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .pkt_truncated(pkt_truncated),
        .pkt_aborted  (pkt_aborted)
    );

    always #5 clk = ~clk;

    // Per-source byte FIFOs: {last, data}.
    logic [8:0] smem   [NS][32];
    logic [4:0] wr_ptr [NS] = '{default: 5'd0};
    logic [4:0] rd_ptr [NS] = '{default: 5'd0};

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            src_valid[i]      = (rd_ptr[i] != wr_ptr[i]);
            src_data[8*i +: 8] = smem[i][rd_ptr[i]][7:0];
            src_last[i]       = smem[i][rd_ptr[i]][8];
        end
    end

    // Source model: pop the head byte on each accept pulse.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (src_ready[i]) rd_ptr[i] <= rd_ptr[i] + 5'd1;
        end
    end

    // Transmitter model: after an accepted enable, ready stays low for BUSY clocks.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_enable && tx_ready) begin
            tx_ready <= 1'b0;
            busy_cnt <= BUSY;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_ready <= 1'b1;
        end
    end

    // Monitor. pace_st: 0 = free to issue, 1 = waiting for ready low, 2 = waiting for ready high.
    int         cyc = 0;
    int         last_issue_cyc = 0;
    int         abort_gap = 0;
    int         trunc_cnt = 0;
    int         abort_cnt = 0;
    int         bad_rdy_cnt = 0;
    int         rdy_cnt [NS] = '{default: 0};
    logic [1:0] pace_st = 2'd0;
    logic       pace_ok;
    logic [8:0] obs_q [$];

    assign pace_ok = (pace_st == 2'd0) || ((pace_st == 2'd2) && tx_ready);

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_enable) begin
            obs_q.push_back({pace_ok, tx_data});
            last_issue_cyc <= cyc;
            pace_st <= 2'd1;
        end else if (pace_st == 2'd1 && !tx_ready) begin
            pace_st <= 2'd2;
        end else if (pace_st == 2'd2 && tx_ready) begin
            pace_st <= 2'd0;
        end
        if (pkt_truncated) trunc_cnt <= trunc_cnt + 1;
        if (pkt_aborted) begin
            abort_cnt <= abort_cnt + 1;
            abort_gap <= cyc - last_issue_cyc;
        end
        for (int i = 0; i < NS; i++) begin
            if (src_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
            if (src_ready[i] && !(grant_valid && grant_id == 2'(i))) bad_rdy_cnt <= bad_rdy_cnt + 1;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int src, input logic [7:0] data, input logic last);
        smem[src][wr_ptr[src]] = {last, data};
        wr_ptr[src] = wr_ptr[src] + 5'd1;
    endtask

    task automatic drain(input string tag);
        int         waited;
        logic [8:0] o;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (obs_q.size() == 0 && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
            if (obs_q.size() == 0) begin
                chk({tag, "_timeout"}, 32'(obs_q.size()), 32'd1);
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                chk({tag, "_byte"}, 32'(o[7:0]), 32'(e));
                chk({tag, "_pace"}, 32'(o[8]), 32'd1);
            end
        end
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int n = 0;
        while (tx_ready !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(tx_ready), 32'(lvl));
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        while (tx_enable !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_enable_wait"}, 32'(tx_enable), 32'd1);
    endtask

    task automatic settle(input string tag);
        wait_ready(1'b0, tag);
        wait_ready(1'b1, tag);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_grant_id"},    32'(grant_id), 32'd0);
        chk({tag, "_src_ready"},   32'(src_ready), 32'd0);
        chk({tag, "_tx_enable"},   32'(tx_enable), 32'd0);
        chk({tag, "_tx_data"},     32'(tx_data), 32'd0);
        chk({tag, "_truncated"},   32'(pkt_truncated), 32'd0);
        chk({tag, "_aborted"},     32'(pkt_aborted), 32'd0);
    endtask

    int snap_rdy [NS];
    int snap_trunc;
    int snap_abort;

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Round-robin across sources 0, 1 and 3. Source 0 has a second packet
        // queued behind its first, so source 1 must be served before it.
        snap_rdy = rdy_cnt;
        load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1);
        load(0, 8'h03, 1'b0); load(0, 8'h04, 1'b1);
        load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b1);
        load(3, 8'h31, 1'b0); load(3, 8'h32, 1'b1);
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                  8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
        drain("rr");
        chk("rr_ready0", 32'(rdy_cnt[0] - snap_rdy[0]), 32'd4);
        chk("rr_ready1", 32'(rdy_cnt[1] - snap_rdy[1]), 32'd2);
        chk("rr_ready3", 32'(rdy_cnt[3] - snap_rdy[3]), 32'd2);
        settle("rr");

        // Source 2 sends a single packet. The header issues one cycle after the request.
        snap_rdy = rdy_cnt;
        load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
        @(negedge clk);
        chk("lat_tx_enable", 32'(tx_enable), 32'd1);
        chk("lat_tx_data", 32'(tx_data), 32'hA2);
        drain("s2");
        wait_ready(1'b0, "s2_final");
        wait_ready(1'b1, "s2_final");
        chk("s2_grant_held", 32'(grant_valid), 32'd1);
        repeat (2) @(negedge clk);
        chk("s2_grant_dropped", 32'(grant_valid), 32'd0);
        chk("s2_ready_pulses", 32'(rdy_cnt[2] - snap_rdy[2]), 32'd3);
        repeat (4) @(negedge clk);

        // Truncation: 6 bytes, with src_last only on the 6th. The first 4 bytes
        // form one packet; the rest re-arbitrate behind a new header.
        snap_rdy   = rdy_cnt;
        snap_trunc = trunc_cnt;
        snap_abort = abort_cnt;
        for (int b = 0; b < 6; b++) load(1, 8'(8'h41 + b), (b == 5));
        exp_q = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA1, 8'h45, 8'h46};
        drain("trunc");
        chk("trunc_pulses", 32'(trunc_cnt - snap_trunc), 32'd1);
        chk("trunc_no_abort", 32'(abort_cnt - snap_abort), 32'd0);
        chk("trunc_ready1", 32'(rdy_cnt[1] - snap_rdy[1]), 32'd6);
        settle("trunc");

        // Stall: source 0 stops after one data byte while source 3 waits.
        // The timeout counts only in SEND. After the last issue there are
        // BUSY cycles with ready low, 1 cycle in WAIT_DONE with ready high and
        // 10 stall cycles in SEND; the pulse appears on the next cycle.
        snap_trunc = trunc_cnt;
        snap_abort = abort_cnt;
        load(0, 8'h5A, 1'b0);
        exp_q = '{8'hA0, 8'h5A, 8'hA3, 8'h61, 8'h62};
        wait_enable("stall_hdr");
        @(negedge clk);
        load(3, 8'h61, 1'b0); load(3, 8'h62, 1'b1);
        drain("stall");
        chk("stall_abort_pulses", 32'(abort_cnt - snap_abort), 32'd1);
        chk("stall_abort_gap", 32'(abort_gap), 32'(BUSY + 12));
        chk("stall_no_trunc", 32'(trunc_cnt - snap_trunc), 32'd0);
        settle("stall");

        // Reset while waiting for the transmitter to go busy after source 3's header.
        load(3, 8'h77, 1'b1);
        exp_q = '{8'hA3};
        wait_enable("rst_hdr");
        @(negedge clk);
        load(0, 8'h0A, 1'b0); load(0, 8'h0B, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("midreset");
        @(negedge clk);
        chk("post_rst_grant_valid", 32'(grant_valid), 32'd1);
        chk("post_rst_grant_id", 32'(grant_id), 32'd0);
        chk("post_rst_no_issue", 32'(tx_enable), 32'd0);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h77);
        drain("post_rst");
        settle("post_rst");

        chk("ready_only_granted", 32'(bad_rdy_cnt), 32'd0);
        chk("no_extra_bytes", 32'(obs_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
